// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the alu_mdu execute-stage unit
package alu_pkg;

    localparam int FUNC_W   = 4;
    localparam int NUM_FUNC = 11;

    // Function codes; values 11..15 are unassigned and execute as add
    typedef enum logic [FUNC_W-1:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_SLT  = 4'd2,
        F_EQ   = 4'd3,
        F_NE   = 4'd4,
        F_AND  = 4'd5,
        F_OR   = 4'd6,
        F_XOR  = 4'd7,
        F_SLTU = 4'd8,
        F_MULU = 4'd9,
        F_DIVU = 4'd10
    } alu_func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - shared shift/accumulate datapath for iterative mulu and divu
module alu_seq_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    // r_hi: accumulator (mul) / partial remainder (div)
    // r_lo: multiplier being shifted out (mul) / dividend shifting into quotient (div)
    // r_op: multiplicand (mul) / divisor (div)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_part;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    // One radix-2 step of either shift-add multiply or restoring divide
    always_comb begin
        w_sum     = {1'b0, r_hi} + {1'b0, r_op};
        w_part    = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_op});
        // When w_ge holds the difference is below 2^WIDTH, so the low bits suffice
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_op;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (r_div) begin
            w_hi_next = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_next = w_part[WIDTH:1];
            w_lo_next = {w_part[0], r_lo[WIDTH-1:1]};
        end
    end

    // Load operands on start, then iterate until the counter drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_op  <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_hi  <= '0;
            r_lo  <= i_div ? i_a : i_b;
            r_op  <= i_div ? i_b : i_a;
            r_cnt <= CNT_W'(WIDTH);
            r_div <= i_div;
        end else if (r_cnt != '0) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Done flags the final iteration; the owner captures the *_next values that cycle
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_hi_next = w_hi_next;
    assign o_lo_next = w_lo_next;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - handshaked ALU with iterative unsigned multiply and divide
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  res,
    output logic [WIDTH-1:0]  hi,
    output logic              carry,
    output logic              zero,
    output logic              div_zero
);

    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_div_zero;
    logic             r_dz_pend;

    alu_func_e        w_func;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_carry;
    logic             w_core_start;
    logic             w_core_div;
    logic             w_load_single;
    logic             w_load_seq;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    assign w_func = alu_func_e'(func);
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Single-cycle function unit; carry is bit WIDTH of the extended add/sub
    always_comb begin
        w_sc_res   = w_sum[WIDTH-1:0];
        w_sc_carry = w_sum[WIDTH];
        case (w_func)
            F_SUB: begin
                w_sc_res   = w_diff[WIDTH-1:0];
                w_sc_carry = w_diff[WIDTH];
            end
            F_SLT:  begin w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))}; w_sc_carry = 1'b0; end
            F_EQ:   begin w_sc_res = {{(WIDTH-1){1'b0}}, (a == b)}; w_sc_carry = 1'b0; end
            F_NE:   begin w_sc_res = {{(WIDTH-1){1'b0}}, (a != b)}; w_sc_carry = 1'b0; end
            F_AND:  begin w_sc_res = a & b; w_sc_carry = 1'b0; end
            F_OR:   begin w_sc_res = a | b; w_sc_carry = 1'b0; end
            F_XOR:  begin w_sc_res = a ^ b; w_sc_carry = 1'b0; end
            F_SLTU: begin w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)}; w_sc_carry = 1'b0; end
            default: begin
                w_sc_res   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
            end
        endcase
    end

    // Next-state and load strobes; inputs only matter while IDLE
    always_comb begin
        w_state_next  = r_state;
        w_core_start  = 1'b0;
        w_core_div    = 1'b0;
        w_load_single = 1'b0;
        w_load_seq    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_func == F_MULU) begin
                        w_core_start = 1'b1;
                        w_state_next = ST_MUL;
                    end else if (w_func == F_DIVU) begin
                        w_core_start = 1'b1;
                        w_core_div   = 1'b1;
                        w_state_next = ST_DIV;
                    end else begin
                        w_load_single = 1'b1;
                        w_state_next  = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_core_done) begin
                    w_load_seq   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result registers; held untouched through DONE so back-pressure sees stable outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res      <= '0;
            r_hi       <= '0;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
            r_dz_pend  <= 1'b0;
        end else if (w_load_single) begin
            r_res      <= w_sc_res;
            r_hi       <= '0;
            r_carry    <= w_sc_carry;
            r_div_zero <= 1'b0;
        end else if (w_core_start) begin
            r_dz_pend  <= w_core_div && (b == '0);
        end else if (w_load_seq) begin
            r_res      <= w_core_lo;
            r_hi       <= w_core_hi;
            r_carry    <= 1'b0;
            r_div_zero <= r_dz_pend;
        end
    end

    alu_seq_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_seq_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_core_start),
        .i_div     (w_core_div),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_core_done),
        .o_hi_next (w_core_hi),
        .o_lo_next (w_core_lo)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign res       = r_res;
    assign hi        = r_hi;
    assign carry     = r_carry;
    assign zero      = (r_res == '0) && !r_carry;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized and directed self-checking bench for alu_mdu
module tb_alu_mdu;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    func;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;
    logic [W-1:0]  hi;
    logic          carry;
    logic          zero;
    logic          div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .hi        (hi),
        .carry     (carry),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain arithmetic on wide integers
    function automatic void ref_model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic [W-1:0] h,
                                      output logic c, output logic dz, output int lat);
        logic [63:0] w;
        r = '0; h = '0; c = 1'b0; dz = 1'b0; lat = 1;
        case (f)
            4'd1: begin w = {32'b0, x} - {32'b0, y}; r = w[31:0]; c = w[32]; end
            4'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd3: r = (x == y) ? 32'd1 : 32'd0;
            4'd4: r = (x != y) ? 32'd1 : 32'd0;
            4'd5: r = x & y;
            4'd6: r = x | y;
            4'd7: r = x ^ y;
            4'd8: r = (x < y) ? 32'd1 : 32'd0;
            4'd9: begin
                w = {32'b0, x} * {32'b0, y};
                r = w[31:0]; h = w[63:32]; lat = W + 1;
            end
            4'd10: begin
                lat = W + 1;
                if (y == 0) begin r = '1; h = x; dz = 1'b1; end
                else begin r = x / y; h = x % y; end
            end
            default: begin w = {32'b0, x} + {32'b0, y}; r = w[31:0]; c = w[32]; end
        endcase
    endfunction

    // Issue one op, measure latency, check result, optionally back-pressure, then release
    task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        logic [W-1:0] er, eh;
        logic ec, edz;
        int lat, cyc, waitc;
        ref_model(f, x, y, er, eh, ec, edz, lat);
        waitc = 0;
        while (!in_ready && waitc < 100) begin @(posedge clk); #1; waitc++; end
        check({tag, " ready_before"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b1; func = f; a = x; b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; func = 4'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " res"}, 64'(res), 64'(er));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " carry"}, 64'(carry), 64'(ec));
        check({tag, " zero"}, 64'(zero), 64'((er == 0) && !ec));
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        check({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; func = 4'd0; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            check({tag, " bp_valid"}, 64'(out_valid), 64'd1);
            check({tag, " bp_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, " bp_res"}, 64'(res), 64'(er));
            check({tag, " bp_hi"}, 64'(hi), 64'(eh));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " released_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; func = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset res", 64'(res), 64'd0);
        check("reset zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; func = 4'd9; a = 32'hDEADBEEF; b = 32'h12345678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul in_ready", 64'(in_ready), 64'd1);
        check("midmul out_valid", 64'(out_valid), 64'd0);
        check("midmul res", 64'(res), 64'd0);
        check("midmul zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_after_reset", 4'd0, 32'd2, 32'd3, 0);

        run_op("sub_neg", 4'd1, 32'd3, 32'd5, 0);
        run_op("sub_eq", 4'd1, 32'd7, 32'd7, 0);
        run_op("add_carry", 4'd0, 32'hFFFFFFFF, 32'd1, 0);
        run_op("slt", 4'd2, 32'hFFFFFFFF, 32'd1, 0);
        run_op("sltu", 4'd8, 32'hFFFFFFFF, 32'd1, 0);
        run_op("and", 4'd5, 32'hF0F0A5A5, 32'h0FF0FF00, 0);
        run_op("or", 4'd6, 32'hF0F0A5A5, 32'h0FF0FF00, 0);
        run_op("xor", 4'd7, 32'hF0F0A5A5, 32'h0FF0FF00, 0);
        run_op("ne", 4'd4, 32'd9, 32'd9, 0);
        run_op("func12_add", 4'd12, 32'd40, 32'd2, 0);
        run_op("mulu_max", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("divu_100_7", 4'd10, 32'd100, 32'd7, 0);
        run_op("divu_by0", 4'd10, 32'd9, 32'd0, 0);
        run_op("eq_backpressure", 4'd3, 32'h1234, 32'h1234, 10);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]   rf;
            logic [W-1:0] ra, rb;
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
            run_op("random", rf, ra, rb, (k % 8 == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing add/sub/slt/eq/ne function codes and adds logic ops, unsigned compare, and iterative unsigned multiply and divide. Each operation is accepted with a valid/ready handshake and returns a registered result. It sits in the execute stage and stalls the pipeline through `in_ready` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands and function are valid.
- `in_ready` out 1: block can accept an operation.
- `a`, `b` in WIDTH: operands.
- `func` in 4: operation code.
- `out_valid` out 1: result outputs are valid.
- `out_ready` in 1: consumer takes the result.
- `res` out WIDTH: primary result (sum, difference, flag, low product, quotient).
- `hi` out WIDTH: high product or remainder; 0 for single-cycle ops.
- `carry` out 1: bit WIDTH of the WIDTH+1-bit add/sub result; 0 otherwise.
- `zero` out 1: `res == 0 && carry == 0`.
- `div_zero` out 1: divu issued with `b == 0`.

## Operation
- func codes:
  - 0 add; 1 sub; 2 slt (signed); 3 eq (res = a==b); 4 ne.
  - 5 and; 6 or; 7 xor; 8 sltu; 9 mulu; 10 divu.
  - Codes 11–15 behave as add.
- FSM states: IDLE, MUL, DIV, DONE.
- `in_ready = (state == IDLE)`. An operation is accepted on a cycle with `in_valid && in_ready`.
- IDLE, accept of a single-cycle op: compute combinationally, register the result, go to DONE.
- IDLE, accept of mulu: latch `a` and `b`, clear the accumulator, set count = WIDTH, go to MUL.
- MUL: shift-add radix-2, one multiplier bit per cycle. Product `{hi,res}` is 2·WIDTH bits, unsigned. After WIDTH iterations, go to DONE.
- IDLE, accept of divu: same latching as mulu, go to DIV.
- DIV: restoring division, one quotient bit per cycle. Result: `res` = quotient, `hi` = remainder. After WIDTH iterations, go to DONE.
- divu with `b == 0`: take the DIV path with no special timing. The result is `res` = all ones, `hi` = `a`, `div_zero` = 1.
- DONE: `out_valid = 1`. Outputs are held stable until `out_ready`. Then go to IDLE.
- Inputs are ignored outside IDLE. Operands are latched at accept, so later changes on `a`/`b` have no effect.
- Reset (any state, including mid-MUL/DIV): state IDLE. Outputs become `res` = 0, `hi` = 0, `carry` = 0, `div_zero` = 0, `out_valid` = 0. `zero` therefore reads 1 and `in_ready` reads 1. The in-flight operation is discarded.

## Timing
- Single-cycle ops: accepted at edge N, `out_valid` high after edge N+1.
- mulu/divu: accepted at edge N, `out_valid` high after edge N+WIDTH+1.
- Throughput: at most one operation per 2 cycles for single-cycle ops. A new op can be accepted in the cycle after the DONE handshake.
- `out_valid` is held indefinitely while `out_ready` is low (back-pressure).
- `in_ready` and `out_valid` are never high in the same cycle.
- No combinational path from inputs to `res`, `hi`, `carry`, `zero`, `div_zero`, or `out_valid`.

## Structure
- Package `alu_pkg`:
  - `func` encoding as a 4-bit enum `alu_func_e`.
  - FSM state enum `alu_state_e`.
  - Constants `FUNC_W = 4` and `NUM_FUNC = 11`.
- Sub-module `alu_seq_core`: shared shift/accumulate datapath for MUL and DIV, with a mode select and done output. The top level holds the FSM, the single-cycle ALU, and the output registers.

## Test plan
- Reset mid-MUL: assert `rst_n` low 5 cycles into a mulu (WIDTH=32). Required: immediately `in_ready` = 1, `out_valid` = 0, `res` = 0, `zero` = 1. The next add 2+3 returns `res` = 5 after 1 cycle.
- sub 3−5, WIDTH=32: required `res` = 0xFFFFFFFE, `carry` = 1, `zero` = 0. Also sub 7−7: required `res` = 0, `carry` = 0, `zero` = 1.
- slt vs sltu with a=0xFFFFFFFF, b=1: slt gives `res` = 1; sltu gives `res` = 0.
- mulu 0xFFFFFFFF × 0xFFFFFFFF: required `hi` = 0xFFFFFFFE, `res` = 0x00000001, `out_valid` exactly 33 cycles after accept.
- divu 100/7: required `res` = 14, `hi` = 2. divu 9/0: required `res` = 0xFFFFFFFF, `hi` = 9, `div_zero` = 1.
- Back-pressure: hold `out_ready` low 10 cycles after an eq result. Required: outputs stable, `in_ready` = 0, `in_valid` ignored. After `out_ready` rises, `in_ready` = 1 on the next cycle.
